// File: rtl/isa_addr_dispatcher_pkg.sv
// Shared types and constants for the ISA address capture read path.
`timescale 1ns/1ps
package isa_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    SEND,
    HOLD
  } disp_state_t;

  localparam logic [19:0] UART_PAGE0_DEF = 20'h02001;
  localparam logic [19:0] UART_PAGE1_DEF = 20'h02002;

  localparam logic [7:0] TAG_UART  = 8'hA5;
  localparam logic [7:0] TAG_OTHER = 8'h5A;

  function automatic logic page_match(input logic [19:0] page,
                                      input logic [19:0] p0,
                                      input logic [19:0] p1);
    return (page == p0) || (page == p1);
  endfunction

endpackage

// File: rtl/isa_addr_dispatcher_if.sv
// FIFO read side and host TX byte link of the ISA address dispatcher.
`timescale 1ns/1ps
interface isa_addr_dispatcher_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_dout;
    logic              fifo_valid;
    logic              fifo_rd_en;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              uart_busy;
    logic [CNT_W-1:0]  sent_cnt;

    modport master (
        input  fifo_empty, fifo_dout, fifo_valid, tx_ready,
        output fifo_rd_en, tx_valid, tx_data, uart_busy, sent_cnt
    );

    modport slave (
        output fifo_empty, fifo_dout, fifo_valid, tx_ready,
        input  fifo_rd_en, tx_valid, tx_data, uart_busy, sent_cnt
    );
endinterface

// File: rtl/isa_byte_serializer.sv
// Holds one captured word and streams it MSB-first over a valid/ready byte link.
// ISA_ADDR_TAG_EN: prepend a page-class tag byte to every word.
`timescale 1ns/1ps
module isa_byte_serializer
    import isa_cap_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [19:0] UART_PAGE0 = UART_PAGE0_DEF,
    parameter logic [19:0] UART_PAGE1 = UART_PAGE1_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] word,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              is_uart,
    output logic              done
);
    localparam int unsigned WORD_BYTES = ADDR_W / 8;
`ifdef ISA_ADDR_TAG_EN
    localparam int unsigned NBYTES = WORD_BYTES + 1;
`else
    localparam int unsigned NBYTES = WORD_BYTES;
`endif
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [ADDR_W-1:0] word_q;
    logic [IDX_W-1:0]  byte_idx;
    logic              start_q;
    logic              last;

    assign is_uart = page_match(word_q[ADDR_W-1 -: 20], UART_PAGE0, UART_PAGE1);
    assign last    = (byte_idx == LAST_IDX);
    assign done    = tx_valid && tx_ready && last;

    // start_q spends one cycle with the word held but not yet offered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
            start_q  <= 1'b0;
            tx_valid <= 1'b0;
        end else if (load) begin
            word_q   <= word;
            byte_idx <= '0;
            start_q  <= 1'b1;
            tx_valid <= 1'b0;
        end else if (start_q) begin
            start_q  <= 1'b0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (last) tx_valid <= 1'b0;
            else      byte_idx <= byte_idx + IDX_W'(1);
        end
    end

    always_comb begin
        tx_data = '0;
        if (tx_valid) begin
`ifdef ISA_ADDR_TAG_EN
            if (byte_idx == '0) tx_data = is_uart ? TAG_UART : TAG_OTHER;
            for (int unsigned i = 0; i < WORD_BYTES; i++)
                if (byte_idx == IDX_W'(i + 1)) tx_data = word_q[ADDR_W-1-8*i -: 8];
`else
            for (int unsigned i = 0; i < WORD_BYTES; i++)
                if (byte_idx == IDX_W'(i)) tx_data = word_q[ADDR_W-1-8*i -: 8];
`endif
        end
    end
endmodule

// File: rtl/isa_addr_dispatcher.sv
// Pops captured ISA addresses one at a time and forwards them as bytes, holding off after UART pages.
// ISA_ADDR_TAG_EN (in isa_byte_serializer): prepend a page-class tag byte to each word.
`timescale 1ns/1ps
module isa_addr_dispatcher
    import isa_cap_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter logic [19:0] UART_PAGE0     = UART_PAGE0_DEF,
    parameter logic [19:0] UART_PAGE1     = UART_PAGE1_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    isa_addr_dispatcher_if.master bus
);
    localparam int unsigned HC_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLDOFF_CYCLES);

    disp_state_t      state_q, state_d;
    logic [HC_W-1:0]  hold_cnt_q;
    logic [CNT_W-1:0] sent_cnt_q;
    logic             uart_busy_q;
    logic             capture_q;
    logic             rd_en;
    logic             load;
    logic             is_uart;
    logic             done;

    isa_byte_serializer #(
        .ADDR_W     (ADDR_W),
        .UART_PAGE0 (UART_PAGE0),
        .UART_PAGE1 (UART_PAGE1)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .word     (bus.fifo_dout),
        .tx_ready (bus.tx_ready),
        .tx_valid (bus.tx_valid),
        .tx_data  (bus.tx_data),
        .is_uart  (is_uart),
        .done     (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: if (!rst && !bus.fifo_empty && hold_cnt_q == '0) begin
                rd_en   = 1'b1;
                state_d = POP;
            end
            POP: if (bus.fifo_valid) begin
                load    = 1'b1;
                state_d = SEND;
            end else begin
                state_d = WAIT;
            end
            WAIT: if (bus.fifo_valid) begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: if (done) state_d = (is_uart && HOLDOFF_CYCLES > 0) ? HOLD : IDLE;
            HOLD: if (hold_cnt_q <= HC_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy rises one cycle after the word lands in the serializer and falls as hold-off expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            sent_cnt_q  <= '0;
            uart_busy_q <= 1'b0;
            capture_q   <= 1'b0;
        end else begin
            capture_q <= load;
            if (capture_q && is_uart) uart_busy_q <= 1'b1;
            if (state_q == SEND && done) begin
                sent_cnt_q <= sent_cnt_q + CNT_W'(1);
                if (is_uart && HOLDOFF_CYCLES > 0) hold_cnt_q  <= HOLD_INIT;
                else                               uart_busy_q <= 1'b0;
            end
            if (state_q == HOLD && hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - HC_W'(1);
                if (hold_cnt_q == HC_W'(1)) uart_busy_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.uart_busy  = uart_busy_q;
    assign bus.sent_cnt   = sent_cnt_q;
endmodule

// File: tb/tb_isa_addr_dispatcher.sv
// Directed bench for isa_addr_dispatcher with a behavioural capture-FIFO model.
`timescale 1ns/1ps
module tb_isa_addr_dispatcher;
    localparam int unsigned CNT_W = 4;
`ifdef ISA_ADDR_TAG_EN
    localparam int unsigned NB = 5;
`else
    localparam int unsigned NB = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic spur_v = 1'b0;
    logic [31:0] spur_d = '0;
    logic m_valid = 1'b0;
    logic [31:0] m_dout = '0;
    logic f_empty = 1'b1;
    logic [31:0] fq[$];

    int unsigned cyc = 0;
    logic [7:0]  rx_b[$];
    int unsigned rx_c[$];
    int unsigned rd_c[$];
    bit          busy_log[int unsigned];
    int unsigned busy_cnt = 0, txv_cnt = 0, stab_err = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  held_data = '0;

    int unsigned n_chk = 0, n_pass = 0;

    always #50 clk = ~clk;

    isa_addr_dispatcher_if #(.ADDR_W(32), .CNT_W(CNT_W)) dut_if ();

    isa_addr_dispatcher #(
        .ADDR_W         (32),
        .HOLDOFF_CYCLES (2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    assign dut_if.fifo_empty = f_empty;
    assign dut_if.fifo_valid = m_valid | spur_v;
    assign dut_if.fifo_dout  = spur_v ? spur_d : m_dout;
    assign dut_if.tx_ready   = rdy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dut_if.fifo_rd_en && fq.size() != 0) begin
            m_dout  <= fq.pop_front();
            m_valid <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
        f_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            busy_log[cyc] = dut_if.uart_busy;
            if (dut_if.uart_busy) busy_cnt++;
            if (dut_if.tx_valid) txv_cnt++;
            if (dut_if.fifo_rd_en) rd_c.push_back(cyc);
            if (hold_prev && (!dut_if.tx_valid || dut_if.tx_data !== held_data)) stab_err++;
            hold_prev = dut_if.tx_valid && !dut_if.tx_ready;
            held_data = dut_if.tx_data;
            if (dut_if.tx_valid && dut_if.tx_ready) begin
                rx_b.push_back(dut_if.tx_data);
                rx_c.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int unsigned i);
        logic [31:0] t;
`ifdef ISA_ADDR_TAG_EN
        if (i == 0) return (w[31:12] == 20'h02001 || w[31:12] == 20'h02002) ? 8'hA5 : 8'h5A;
        t = w << (8 * (i - 1));
`else
        t = w << (8 * i);
`endif
        return t[31:24];
    endfunction

    task automatic wait_bytes(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (rx_b.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, rx_b.size(), n);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic check_word(input string tag, input int unsigned base, input logic [31:0] w);
        for (int unsigned i = 0; i < NB; i++)
            if (base + i < rx_b.size()) check(tag, rx_b[base+i], exp_byte(w, i));
            else check(tag, 32'hFFFF_FFFF, exp_byte(w, i));
    endtask

    initial begin
        int unsigned rb, rdb, bb, tb0, last;
        logic [31:0] wrap_w[17];

        // Reset values, with data already waiting in the FIFO
        fq.push_back(32'h0200_3000);
        fq.push_back(32'h1122_3344);
        idle(3);
        check("rst_rd_en", dut_if.fifo_rd_en, 0);
        check("rst_tx_valid", dut_if.tx_valid, 0);
        check("rst_tx_data", dut_if.tx_data, 0);
        check("rst_uart_busy", dut_if.uart_busy, 0);
        check("rst_sent_cnt", dut_if.sent_cnt, 0);

        // Non-UART word, then immediate next pop
        rb = rx_b.size(); rdb = rd_c.size(); bb = busy_cnt;
        @(posedge clk); #1 rst = 1'b0;
        wait_bytes(rb + 2 * NB, 60, "t1_timeout");
        idle(1);
        check_word("t1_word0", rb, 32'h0200_3000);
        check_word("t1_word1", rb + NB, 32'h1122_3344);
        check("t1_latency", rx_c[rb] - rd_c[rdb], 3);
        check("t1_back2back", rx_c[rb+NB-1] - rx_c[rb], NB - 1);
        check("t1_next_pop", rd_c[rdb+1] - rx_c[rb+NB-1], 1);
        check("t1_busy", busy_cnt - bb, 0);
        check("t1_sent_cnt", dut_if.sent_cnt, 2);

        // Two UART-page words: two-cycle hold-off between them
        idle(3);
        rb = rx_b.size(); rdb = rd_c.size();
        fq.push_back(32'h0200_1000);
        fq.push_back(32'h0200_2000);
        wait_bytes(rb + 2 * NB, 80, "t2_timeout");
        idle(4);
        last = rx_c[rb+NB-1];
        check_word("t2_word0", rb, 32'h0200_1000);
        check_word("t2_word1", rb + NB, 32'h0200_2000);
        check("t2_busy_capture", busy_log[rd_c[rdb]+2], 0);
        check("t2_busy_rise", busy_log[rd_c[rdb]+3], 1);
        check("t2_gap", rd_c[rdb+1] - last, 3);
        check("t2_busy_hold1", busy_log[last+1], 1);
        check("t2_busy_hold2", busy_log[last+2], 1);
        check("t2_busy_fall", busy_log[last+3], 0);
        check("t2_busy_end", dut_if.uart_busy, 0);
        check("t2_sent_cnt", dut_if.sent_cnt, 4);

        // tx_ready toggling every cycle
        rb = rx_b.size();
        fq.push_back(32'hCAFE_F00D);
        fq.push_back(32'h1234_5678);
        tb0 = 0;
        while (rx_b.size() < rb + 2 * NB && tb0 < 100) begin
            @(posedge clk); #1 rdy = ~rdy;
            tb0++;
        end
        rdy = 1'b1;
        check("t3_timeout", rx_b.size(), rb + 2 * NB);
        idle(2);
        check_word("t3_word0", rb, 32'hCAFE_F00D);
        check_word("t3_word1", rb + NB, 32'h1234_5678);
        check("t3_stable", stab_err, 0);
        check("t3_sent_cnt", dut_if.sent_cnt, 6);

        // Reset in the middle of a word
        idle(2);
        rb = rx_b.size();
        fq.push_back(32'h89AB_CDEF);
        wait_bytes(rb + 2, 40, "t4_timeout");
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("t4_rst_tx_valid", dut_if.tx_valid, 0);
        check("t4_rst_tx_data", dut_if.tx_data, 0);
        check("t4_rst_rd_en", dut_if.fifo_rd_en, 0);
        check("t4_rst_sent_cnt", dut_if.sent_cnt, 0);
        fq.push_back(32'h1357_9BDF);
        idle(2);
        rb = rx_b.size();
        @(posedge clk); #1 rst = 1'b0;
        wait_bytes(rb + NB, 40, "t4_restart_timeout");
        idle(1);
        check_word("t4_restart", rb, 32'h1357_9BDF);
        check("t4_sent_cnt", dut_if.sent_cnt, 1);

        // Spurious fifo_valid while idle
        idle(3);
        tb0 = txv_cnt; rdb = rd_c.size();
        @(posedge clk); #1 begin spur_v = 1'b1; spur_d = 32'hDEAD_BEEF; end
        @(posedge clk); #1 spur_v = 1'b0;
        idle(8);
        check("t5_no_tx", txv_cnt - tb0, 0);
        check("t5_no_pop", rd_c.size() - rdb, 0);
        check("t5_sent_cnt", dut_if.sent_cnt, 1);

        // 2^CNT_W + 1 words: counter wraps to 1
        @(posedge clk); #1 rst = 1'b1;
        idle(2);
        rb = rx_b.size();
        for (int unsigned i = 0; i < 17; i++) begin
            wrap_w[i] = 32'h4000_0000 | (i * 32'h0001_0101);
            fq.push_back(wrap_w[i]);
        end
        @(posedge clk); #1 rst = 1'b0;
        wait_bytes(rb + 17 * NB, 500, "t6_timeout");
        idle(2);
        check_word("t6_first", rb, wrap_w[0]);
        check_word("t6_last", rb + 16 * NB, wrap_w[16]);
        check("t6_sent_cnt_wrap", dut_if.sent_cnt, 1);
        check("t6_tx_idle", dut_if.tx_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
